// File: rtl/fxp_pkg.sv
// fxp_pkg: shared definitions for the fixed-point MAC datapath.
//   - width helpers for the product and accumulator
//   - FSM state encoding of the MAC frame controller
//   - saturation bounds of a DW-bit signed result
package fxp_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } fxp_state_e;

    // Full-precision product width of two DW-bit operands.
    function automatic int fxp_pw(input int dw);
        return 32'sd2 * dw;
    endfunction

    // Accumulator width: product plus enough guard bits for maxlen products.
    function automatic int fxp_aw(input int dw, input int maxlen);
        return fxp_pw(dw) + $clog2(maxlen);
    endfunction

    // Largest representable DW-bit signed value.
    function automatic longint fxp_sat_max(input int dw);
        return (64'sd1 <<< (dw - 32'sd1)) - 64'sd1;
    endfunction

    // Smallest representable DW-bit signed value.
    function automatic longint fxp_sat_min(input int dw);
        return -(64'sd1 <<< (dw - 32'sd1));
    endfunction

endpackage

// File: rtl/fxp_sat.sv
// fxp_sat: combinational requantiser. Drops the FW fraction bits of an
// AW-bit accumulator (arithmetic shift, i.e. truncation toward -inf) and
// clips the result to the DW-bit signed range.
//   acc : signed AW-bit value with 2*FW fraction bits
//   z   : DW-bit signed result with FW fraction bits
//   sat : 1 when clipping changed the value
import fxp_pkg::*;

module fxp_sat #(
    parameter int DW = 16,
    parameter int FW = 8,
    parameter int AW = 40
) (
    input  logic signed [AW-1:0] acc,
    output logic        [DW-1:0] z,
    output logic                 sat
);

    localparam logic signed [AW-1:0] ZMAX = AW'(fxp_sat_max(DW));
    localparam logic signed [AW-1:0] ZMIN = AW'(fxp_sat_min(DW));

    logic signed [AW-1:0] shifted_s;

    // Shift out the extra fraction bits, then clip to the result range.
    always_comb begin
        shifted_s = acc >>> FW;
        z         = shifted_s[DW-1:0];
        sat       = 1'b0;
        if (shifted_s > ZMAX) begin
            z   = ZMAX[DW-1:0];
            sat = 1'b1;
        end else if (shifted_s < ZMIN) begin
            z   = ZMIN[DW-1:0];
            sat = 1'b1;
        end else begin
            z   = shifted_s[DW-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/fxp_mac.sv
// fxp_mac: signed fixed-point multiply-accumulate over in_last-delimited
// frames, emitting one requantised and saturated result per frame.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_a, in_b, in_last payload
//   out_valid/out_ready : result handshake; out_z, out_sat, out_err payload
//   out_err flags a frame longer than MAXLEN samples.
import fxp_pkg::*;

module fxp_mac #(
    parameter int DW     = 16,
    parameter int FW     = 8,
    parameter int MAXLEN = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic        [DW-1:0] out_z,
    output logic                 out_sat,
    output logic                 out_err
);

    localparam int PW = fxp_pw(DW);
    localparam int AW = fxp_aw(DW, MAXLEN);
    localparam int LW = AW - PW;
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXLEN);

    fxp_state_e           state_r;
    logic signed [PW-1:0] prod_r;
    logic                 prod_last_r;
    logic                 prod_vld_r;
    logic signed [AW-1:0] acc_r;
    logic        [CW-1:0] cnt_r;

    logic                 accept_s;
    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] b_ext_s;
    logic signed [PW-1:0] prod_s;
    logic signed [AW-1:0] prod_ext_s;
    logic signed [AW-1:0] final_s;
    logic        [DW-1:0] sat_z_s;
    logic                 sat_s;

    // Operand acceptance and full-precision product, plus stage-2 sum.
    always_comb begin
        accept_s   = in_valid & in_ready;
        a_ext_s    = {{DW{in_a[DW-1]}}, in_a};
        b_ext_s    = {{DW{in_b[DW-1]}}, in_b};
        prod_s     = a_ext_s * b_ext_s;
        prod_ext_s = {{LW{prod_r[PW-1]}}, prod_r};
        final_s    = acc_r + prod_ext_s;
    end

    fxp_sat #(
        .DW (DW),
        .FW (FW),
        .AW (AW)
    ) u_sat (
        .acc (final_s),
        .z   (sat_z_s),
        .sat (sat_s)
    );

    // Stage 1: register the product of each accepted pair with its last flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r      <= '0;
            prod_last_r <= 1'b0;
            prod_vld_r  <= 1'b0;
        end else begin
            prod_vld_r <= accept_s;
            if (accept_s) begin
                prod_r      <= prod_s;
                prod_last_r <= in_last;
            end else begin
                prod_last_r <= 1'b0;
            end
        end
    end

    // Stage 2 accumulation, frame finish and the ACC/DRAIN/OUT controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
            acc_r     <= '0;
            cnt_r     <= '0;
        end else begin
            if (prod_vld_r) begin
                if (prod_last_r) begin
                    out_z   <= sat_z_s;
                    out_sat <= sat_s;
                    // Counter already at MAXLEN means the last pair is beyond it.
                    out_err <= (cnt_r == CNT_MAX);
                    acc_r   <= '0;
                    cnt_r   <= '0;
                end else begin
                    acc_r <= final_s;
                    // Saturate so very long frames cannot wrap the error flag away.
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
            end

            case (state_r)
                ST_ACC: begin
                    if (accept_s && in_last) begin
                        state_r  <= ST_DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The last product finishes the frame on this edge.
                    state_r   <= ST_OUT;
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_r   <= ST_ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_ACC;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_mac.sv
// tb_fxp_mac: directed and randomized checks of fxp_mac against a
// plain-arithmetic frame model (integer sum of products, floor shift, clip).
module tb_fxp_mac;

    localparam int DW     = 16;
    localparam int FW     = 8;
    localparam int MAXLEN = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_z;
    logic          out_sat;
    logic          out_err;

    int n_asrt = 0;
    int n_fail = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    fxp_mac #(.DW(DW), .FW(FW), .MAXLEN(MAXLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_sat   (out_sat),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends the frame held in qa/qb, then checks the result and handshake.
    // hold = number of cycles out_ready stays low once the result is up.
    task automatic run_frame(input int hold);
        longint        sum = 0;
        longint        sh;
        longint        zmax = (longint'(1) << (DW - 1)) - 1;
        longint        zmin = -(longint'(1) << (DW - 1));
        logic [DW-1:0] ez;
        logic          es;
        logic          ee;
        int            n = qa.size();
        int            g;
        for (int i = 0; i < n; i++)
            sum += longint'($signed(qa[i])) * longint'($signed(qb[i]));
        sh = sum >>> FW;
        if (sh > zmax) begin ez = DW'(zmax); es = 1'b1; end
        else if (sh < zmin) begin ez = DW'(zmin); es = 1'b1; end
        else begin ez = DW'(sh); es = 1'b0; end
        ee = (n > MAXLEN);

        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a     = qa[i];
            in_b     = qb[i];
            in_last  = (i == n - 1);
            g = 0;
            while (!in_ready && g < 16) begin
                step();
                g++;
            end
            chk("in_ready_accept", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);

        // One edge after the last-accept edge: still draining.
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("out_valid_rise", 32'(out_valid), 32'd1);
        chk("out_z", 32'(out_z), 32'(ez));
        chk("out_sat", 32'(out_sat), 32'(es));
        chk("out_err", 32'(out_err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_z", 32'(out_z), 32'(ez));
            chk("hold_sat", 32'(out_sat), 32'(es));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        step();

        // Single sample 1.5 * 2.0 = 3.0
        qa.push_back(16'h0180); qb.push_back(16'h0200); run_frame(0);
        // Truncation toward -inf
        qa.push_back(16'h0001); qb.push_back(16'h0080); run_frame(0);
        qa.push_back(16'hFFFF); qb.push_back(16'h0080); run_frame(0);
        // Saturation both ways
        for (int i = 0; i < 4; i++) begin qa.push_back(16'h7FFF); qb.push_back(16'h7FFF); end
        run_frame(0);
        for (int i = 0; i < 4; i++) begin qa.push_back(16'h8000); qb.push_back(16'h7FFF); end
        run_frame(1);
        // Backpressure: 3 x 1.0*1.0 with out_ready low 5 cycles
        for (int i = 0; i < 3; i++) begin qa.push_back(16'h0100); qb.push_back(16'h0100); end
        run_frame(5);

        // Reset mid-frame: two pairs accepted, then reset, then a fresh frame.
        in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0100; in_last = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        qa.push_back(16'h0100); qb.push_back(16'h0100); run_frame(0);

        // Reset while a result is waiting.
        in_valid = 1'b1; in_a = 16'h0200; in_b = 16'h0200; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        step();
        chk("pre_outrst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("outrst_valid", 32'(out_valid), 32'd0);
        chk("outrst_z", 32'(out_z), 32'd0);
        chk("outrst_in_ready", 32'(in_ready), 32'd1);

        // Exactly MAXLEN samples is legal, MAXLEN+1 is flagged, then legal again.
        for (int i = 0; i < MAXLEN; i++) begin qa.push_back(16'h0010); qb.push_back(16'h0010); end
        run_frame(0);
        for (int i = 0; i < MAXLEN + 1; i++) begin qa.push_back(16'h0010); qb.push_back(16'h0010); end
        run_frame(0);
        qa.push_back(16'h0300); qb.push_back(16'hFE00); run_frame(0);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            int len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                qa.push_back(16'($urandom));
                qb.push_back(16'($urandom));
            end
            run_frame($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
